stump_control: RTL

Stump control unit: a three-state sequencer (FETCH, EXECUTE, MEMORY) that decodes the instruction register, drives every datapath select line, and holds the condition-code register. It feeds the ALU (`alu_func`) and the shifter (`shift_op`), and consumes the ALU's `flags_out` {N,Z,V,C}, latching them into `cc` for conditional branches. It sits beside the register bank and memory interface in the Stump datapath.

---
 rtl/stump_control_pkg.sv | 53 +++++
 rtl/stump_cond_eval.sv | 40 ++++
 rtl/stump_control.sv | 124 ++++++++++++
 3 files changed

// File: rtl/stump_control_pkg.sv
// rtl/stump_control_pkg.sv - Stump control state codes, opcode and condition names, instruction fields
package stump_control_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        MEMORY  = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADC  = 3'b001,
        OP_SUB  = 3'b010,
        OP_SBC  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_LDST = 3'b110,
        OP_BCC  = 3'b111
    } opcode_t;

    typedef enum logic [3:0] {
        COND_AL = 4'h0,
        COND_NV = 4'h1,
        COND_HI = 4'h2,
        COND_LS = 4'h3,
        COND_CC = 4'h4,
        COND_CS = 4'h5,
        COND_NE = 4'h6,
        COND_EQ = 4'h7,
        COND_VC = 4'h8,
        COND_VS = 4'h9,
        COND_PL = 4'hA,
        COND_MI = 4'hB,
        COND_GE = 4'hC,
        COND_LT = 4'hD,
        COND_GT = 4'hE,
        COND_LE = 4'hF
    } cond_t;

    // Field view of the 16-bit instruction word; branch condition overlays {sl, dst}.
    typedef struct packed {
        opcode_t    opcode;
        logic       imm;
        logic       sl;
        logic [2:0] dst;
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] shift;
    } instr_t;

    localparam logic [2:0] PC_REG = 3'd7;

endpackage

// File: rtl/stump_cond_eval.sv
// rtl/stump_cond_eval.sv - branch condition evaluation against the {N,Z,V,C} register
module stump_cond_eval
    import stump_control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       taken
);

    logic n, z, v, c;

    assign n = cc[3];
    assign z = cc[2];
    assign v = cc[1];
    assign c = cc[0];

    // Carry is not-borrow, so unsigned "higher" is C set and Z clear.
    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond))
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_CC: taken = ~c;
            COND_CS: taken = c;
            COND_NE: taken = ~z;
            COND_EQ: taken = z;
            COND_VC: taken = ~v;
            COND_VS: taken = v;
            COND_PL: taken = ~n;
            COND_MI: taken = n;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = ~z & (n == v);
            COND_LE: taken = z | (n != v);
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// rtl/stump_control.sv - Stump FETCH/EXECUTE/MEMORY sequencer, datapath select decode and CC register
module stump_control
    import stump_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags_in,
    output logic        fetch,
    output logic        execute,
    output logic        memory,
    output logic [2:0]  alu_func,
    output logic [1:0]  shift_op,
    output logic        opB_mux_sel,
    output logic        ext_op,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [2:0]  dest,
    output logic        reg_write,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  cc
);

    state_t state;
    state_t state_next;
    instr_t f;
    logic   alu_op;
    logic   taken;

    assign f      = instr_t'(ir);
    assign alu_op = (f.opcode != OP_LDST) && (f.opcode != OP_BCC);

    stump_cond_eval u_cond_eval (
        .cond  (ir[11:8]),
        .cc    (cc),
        .taken (taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = EXECUTE;
            EXECUTE: state_next = (f.opcode == OP_LDST) ? MEMORY : FETCH;
            MEMORY:  state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Flags are captured only by ALU ops with S set; memory and branch ops leave cc alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc <= 4'b0000;
        end else if (state == EXECUTE && alu_op && f.sl) begin
            cc <= flags_in;
        end
    end

    always_comb begin
        fetch       = 1'b0;
        execute     = 1'b0;
        memory      = 1'b0;
        alu_func    = 3'b000;
        shift_op    = 2'b00;
        opB_mux_sel = 1'b0;
        ext_op      = 1'b0;
        srcA        = 3'd0;
        srcB        = 3'd0;
        dest        = 3'd0;
        reg_write   = 1'b0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        case (state)
            FETCH: begin
                fetch = 1'b1;
            end
            EXECUTE: begin
                execute  = 1'b1;
                alu_func = f.opcode;
                if (f.opcode == OP_BCC) begin
                    srcA        = PC_REG;
                    opB_mux_sel = 1'b1;
                    ext_op      = 1'b1;
                    dest        = PC_REG;
                    reg_write   = taken;
                end else begin
                    srcA = f.a;
                    if (alu_op) begin
                        dest      = f.dst;
                        reg_write = 1'b1;
                    end
                    if (f.imm) begin
                        opB_mux_sel = 1'b1;
                    end else begin
                        srcB     = f.b;
                        shift_op = f.shift;
                    end
                end
            end
            MEMORY: begin
                memory = 1'b1;
                if (f.sl) begin
                    mem_wen = 1'b1;
                    srcA    = f.dst;
                end else begin
                    mem_ren   = 1'b1;
                    reg_write = 1'b1;
                    dest      = f.dst;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
